// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-test BIST initiator for a 4096x64 dual-port RAM.
// Runs four phases: write P ascending, read/check P ascending,
// write ~P descending, read/check ~P descending. Each read phase is followed
// by a drain of RD_LATENCY cycles so every outstanding compare completes.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   start                           begin a test (accepted only in IDLE)
//   ram_rdata                       RAM read data
//   ram_wdata/ram_wr_addr/ram_write RAM write port
//   ram_rd_addr/ram_read            RAM read port
//   busy, done, fail                status (done and fail are sticky)
//   fail_addr, fail_data            address and data of the first mismatch
//   err_count                       saturating mismatch count
module ram_bist_ctrl #(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       ADDR_W     = 12,
  parameter int unsigned       RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] PATTERN    = DATA_W'(64'hA5A5_5A5A_0F0F_F0F0),
  parameter int unsigned       ERR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              ram_write,
  output logic              ram_read,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned       REPS       = DATA_W / ADDR_W + 1;
  localparam int unsigned       LAT_W      = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
  localparam logic [LAT_W-1:0]  DRAIN_LAST = LAT_W'(RD_LATENCY - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX    = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    W_P   = 3'd1,
    R_P   = 3'd2,
    DR_P  = 3'd3,
    W_NP  = 3'd4,
    R_NP  = 3'd5,
    DR_NP = 3'd6,
    FIN   = 3'd7
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  drain_cnt;
  logic              rd_inv;

  // Expected-data pipe aligned with the RAM read latency.
  logic              pipe_vld  [RD_LATENCY];
  logic [ADDR_W-1:0] pipe_addr [RD_LATENCY];
  logic [DATA_W-1:0] pipe_exp  [RD_LATENCY];

  logic              cmp_vld_c;
  logic              mismatch_c;

  // Pattern: the address replicated across the word (bit i = a[i % ADDR_W]),
  // xored into PATTERN, optionally inverted.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
    logic [REPS*ADDR_W-1:0] rep;
    rep = {REPS{a}};
    return PATTERN ^ rep[DATA_W-1:0] ^ {DATA_W{inv}};
  endfunction

  // Case inequality so that X/Z read data is flagged in simulation.
  assign cmp_vld_c  = pipe_vld[RD_LATENCY-1];
  assign mismatch_c = cmp_vld_c && (ram_rdata !== pipe_exp[RD_LATENCY-1]);

  // Stage 0 captures the strobe driven this cycle; the tail lines up with valid ram_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_addr[i] <= '0;
        pipe_exp[i]  <= '0;
      end
    end else begin
      pipe_vld[0]  <= ram_read;
      pipe_addr[0] <= ram_rd_addr;
      pipe_exp[0]  <= pat(ram_rd_addr, rd_inv);
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
      end
    end
  end

  // March sequencer, strobe generation and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      rd_inv      <= 1'b0;
      ram_wdata   <= '0;
      ram_wr_addr <= '0;
      ram_rd_addr <= '0;
      ram_write   <= 1'b0;
      ram_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
      err_count   <= '0;
    end else begin
      ram_write <= 1'b0;
      ram_read  <= 1'b0;

      // Compares never coincide with the IDLE clear: the pipe is empty by then.
      if (mismatch_c) begin
        if (err_count != ERR_MAX) begin
          err_count <= err_count + ERR_W'(1);
        end
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= pipe_addr[RD_LATENCY-1];
          fail_data <= ram_rdata;
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= W_P;
            busy        <= 1'b1;
            done        <= 1'b0;
            fail        <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
            err_count   <= '0;
            ram_write   <= 1'b1;
            ram_wr_addr <= ADDR_FIRST;
            ram_wdata   <= pat(ADDR_FIRST, 1'b0);
          end
        end

        // The write/read address registers double as the phase counters.
        W_P: begin
          if (ram_wr_addr == ADDR_LAST) begin
            state       <= R_P;
            ram_read    <= 1'b1;
            ram_rd_addr <= ADDR_FIRST;
            rd_inv      <= 1'b0;
          end else begin
            ram_write   <= 1'b1;
            ram_wr_addr <= ram_wr_addr + ADDR_W'(1);
            ram_wdata   <= pat(ram_wr_addr + ADDR_W'(1), 1'b0);
          end
        end

        R_P: begin
          if (ram_rd_addr == ADDR_LAST) begin
            state     <= DR_P;
            drain_cnt <= '0;
          end else begin
            ram_read    <= 1'b1;
            ram_rd_addr <= ram_rd_addr + ADDR_W'(1);
          end
        end

        DR_P: begin
          if (drain_cnt == DRAIN_LAST) begin
            state       <= W_NP;
            ram_write   <= 1'b1;
            ram_wr_addr <= ADDR_LAST;
            ram_wdata   <= pat(ADDR_LAST, 1'b1);
          end else begin
            drain_cnt <= drain_cnt + LAT_W'(1);
          end
        end

        W_NP: begin
          if (ram_wr_addr == ADDR_FIRST) begin
            state       <= R_NP;
            ram_read    <= 1'b1;
            ram_rd_addr <= ADDR_LAST;
            rd_inv      <= 1'b1;
          end else begin
            ram_write   <= 1'b1;
            ram_wr_addr <= ram_wr_addr - ADDR_W'(1);
            ram_wdata   <= pat(ram_wr_addr - ADDR_W'(1), 1'b1);
          end
        end

        R_NP: begin
          if (ram_rd_addr == ADDR_FIRST) begin
            state     <= DR_NP;
            drain_cnt <= '0;
          end else begin
            ram_read    <= 1'b1;
            ram_rd_addr <= ram_rd_addr - ADDR_W'(1);
          end
        end

        DR_NP: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + LAT_W'(1);
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
